ddr_step_judge: RTL

Judging stage between the NES controller decoder and the score display. It accepts each new arrow issued by the move generator and opens a timed response window. It judges the first button press edge inside that window as a hit or a miss, and keeps a two-digit BCD score (00–99, wrapping) for the 7-segment digit drivers. It replaces ad-hoc score sampling on the slow move clock with single-clock, edge-accurate judging.

---
 rtl/ddr_pkg.sv | 26 ++
 rtl/ddr_bcd_counter2.sv | 62 ++++++
 rtl/ddr_step_judge.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/ddr_pkg.sv
// Shared constants and types for the DDR step judging path.
package ddr_pkg;

    localparam int unsigned DIR_W           = 2;
    localparam int unsigned BTN_W           = 4;
    localparam int unsigned BCD_W           = 4;
    localparam int unsigned COMBO_W         = 4;
    localparam int unsigned COMBO_MAX       = 15;
    localparam int unsigned COMBO_BONUS_MIN = 4;

    localparam logic [DIR_W-1:0] DIR_UP    = 2'b00;
    localparam logic [DIR_W-1:0] DIR_RIGHT = 2'b01;
    localparam logic [DIR_W-1:0] DIR_LEFT  = 2'b10;
    localparam logic [DIR_W-1:0] DIR_DOWN  = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } judge_state_t;

    // Button vector bit that corresponds to an arrow code ({down,left,right,up}).
    function automatic logic [BTN_W-1:0] dir_onehot(input logic [DIR_W-1:0] dir);
        dir_onehot = BTN_W'(1) << dir;
    endfunction

endpackage

// File: rtl/ddr_bcd_counter2.sv
// Two-digit BCD accumulator (00-99, wraps) with add-1 / add-2 steps and a
// synchronous active-low clear. Shared with the display path.
module ddr_bcd_counter2
    import ddr_pkg::*;
(
    input  logic             clk,
    input  logic             i_clr_n,
    input  logic             i_add1,
    input  logic             i_add2,
    output logic [BCD_W-1:0] o_ones,
    output logic [BCD_W-1:0] o_tens
);

    localparam logic [BCD_W:0]   ONES_TEN = (BCD_W+1)'(10);
    localparam logic [BCD_W-1:0] TENS_MAX = BCD_W'(9);

    logic [BCD_W-1:0] r_ones;
    logic [BCD_W-1:0] r_tens;
    logic [1:0]       w_inc;
    logic [BCD_W:0]   w_ones_sum;
    logic [BCD_W-1:0] w_ones_nxt;
    logic [BCD_W-1:0] w_tens_nxt;
    logic             w_carry;

    // Add the requested step to the ones digit and ripple a carry into tens.
    always_comb begin
        w_inc      = 2'd0;
        w_carry    = 1'b0;
        w_ones_nxt = r_ones;
        w_tens_nxt = r_tens;
        if (i_add2) begin
            w_inc = 2'd2;
        end else if (i_add1) begin
            w_inc = 2'd1;
        end
        w_ones_sum = (BCD_W+1)'(r_ones) + (BCD_W+1)'(w_inc);
        if (w_ones_sum >= ONES_TEN) begin
            w_ones_nxt = BCD_W'(w_ones_sum - ONES_TEN);
            w_carry    = 1'b1;
        end else begin
            w_ones_nxt = BCD_W'(w_ones_sum);
        end
        if (w_carry) begin
            w_tens_nxt = (r_tens == TENS_MAX) ? '0 : r_tens + BCD_W'(1);
        end
    end

    // Digit registers.
    always_ff @(posedge clk) begin
        if (!i_clr_n) begin
            r_ones <= '0;
            r_tens <= '0;
        end else begin
            r_ones <= w_ones_nxt;
            r_tens <= w_tens_nxt;
        end
    end

    assign o_ones = r_ones;
    assign o_tens = r_tens;

endmodule

// File: rtl/ddr_step_judge.sv
// Step judge: opens a response window per arrow, judges the first button
// press edge as hit/miss, and keeps a BCD score.
// Optional combo counter and score bonus: define DDR_JUDGE_COMBO_EN.
module ddr_step_judge
    import ddr_pkg::*;
#(
    parameter int unsigned WINDOW_CYCLES = 25_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       move_valid,
    input  logic [1:0] move_dir,
    input  logic       up,
    input  logic       down,
    input  logic       left,
    input  logic       right,
    output logic       judging,
    output logic       hit,
    output logic       miss,
    output logic [3:0] score_ones,
    output logic [3:0] score_tens,
    output logic [3:0] combo
);

    localparam int unsigned      CNT_W    = $clog2(WINDOW_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WINDOW_CYCLES - 1);

    judge_state_t     r_state;
    judge_state_t     w_state_nxt;
    logic [BTN_W-1:0] r_prev_btn;
    logic [BTN_W-1:0] w_btn;
    logic [BTN_W-1:0] w_press;
    logic             w_press_match;
    logic [DIR_W-1:0] r_dir;
    logic [CNT_W-1:0] r_win_cnt;
    logic             w_arm;
    logic             w_hit_d;
    logic             w_miss_d;
    logic             w_add1;
    logic             w_add2;
    logic             r_hit;
    logic             r_miss;

    assign w_btn         = {down, left, right, up};
    assign w_press       = w_btn & ~r_prev_btn;
    assign w_press_match = (w_press == dir_onehot(r_dir));

    // Previous button levels; reset to all-high so held buttons are not presses.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_prev_btn <= '1;
        end else begin
            r_prev_btn <= w_btn;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state; a new move always (re-)arms the window.
    always_comb begin
        w_state_nxt = r_state;
        w_arm       = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (move_valid) begin
                    w_arm       = 1'b1;
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (move_valid) begin
                    w_arm       = 1'b1;
                    w_state_nxt = ST_WAIT;
                end else if ((w_press != '0) || (r_win_cnt == '0)) begin
                    w_state_nxt = ST_IDLE;
                end
            end
        endcase
    end

    // FSM outputs: verdict for the open window, judged against the old arrow.
    always_comb begin
        w_hit_d  = 1'b0;
        w_miss_d = 1'b0;
        if (r_state == ST_WAIT) begin
            if (w_press != '0) begin
                w_hit_d  = w_press_match;
                w_miss_d = !w_press_match;
            end else if (move_valid || (r_win_cnt == '0)) begin
                w_miss_d = 1'b1;
            end
        end
    end

    // Latched arrow and window countdown.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_dir     <= DIR_UP;
            r_win_cnt <= '0;
        end else if (w_arm) begin
            r_dir     <= move_dir;
            r_win_cnt <= CNT_LOAD;
        end else if ((r_state == ST_WAIT) && (r_win_cnt != '0)) begin
            r_win_cnt <= r_win_cnt - CNT_W'(1);
        end
    end

    // Registered verdict pulses.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_hit  <= 1'b0;
            r_miss <= 1'b0;
        end else begin
            r_hit  <= w_hit_d;
            r_miss <= w_miss_d;
        end
    end

`ifdef DDR_JUDGE_COMBO_EN
    logic [COMBO_W-1:0] r_combo;

    // Consecutive-hit counter, saturating; any miss clears it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_combo <= '0;
        end else if (w_hit_d) begin
            if (r_combo != COMBO_W'(COMBO_MAX)) begin
                r_combo <= r_combo + COMBO_W'(1);
            end
        end else if (w_miss_d) begin
            r_combo <= '0;
        end
    end

    assign w_add2 = w_hit_d && (r_combo >= COMBO_W'(COMBO_BONUS_MIN));
    assign combo  = r_combo;
`else
    assign w_add2 = 1'b0;
    assign combo  = '0;
`endif

    assign w_add1 = w_hit_d && !w_add2;

    ddr_bcd_counter2 u_score (
        .clk     (clk),
        .i_clr_n (reset),
        .i_add1  (w_add1),
        .i_add2  (w_add2),
        .o_ones  (score_ones),
        .o_tens  (score_tens)
    );

    assign judging = (r_state == ST_WAIT);
    assign hit     = r_hit;
    assign miss    = r_miss;

endmodule
